// File: rtl/sha3_absorb_pad.sv
// rtl/sha3_absorb_pad.sv - SHA3-256 rate-block packer with pad10*1 padding
module sha3_absorb_pad #(
    parameter int         RATE_WORDS  = 34,
    parameter logic [7:0] DOMAIN_BYTE = 8'h06
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_data,
    input  logic                    in_last,
    input  logic [2:0]              in_bytes,
    output logic                    blk_valid,
    input  logic                    blk_ready,
    output logic [32*RATE_WORDS-1:0] blk_data,
    output logic                    blk_last,
    output logic                    busy
);
    localparam int RATE_BYTES = 4 * RATE_WORDS;
    localparam int BW         = 32 * RATE_WORDS;
    localparam int CW         = $clog2(RATE_WORDS);

    typedef enum logic [1:0] {FILL, EMIT, FINAL} state_t;

    state_t        state;
    logic [CW-1:0] word_cnt;
    logic          pend_pad;
    logic [BW-1:0] blk_buf;

    logic [BW-1:0] fill_next;
    logic [BW-1:0] pad_block;
    logic [2:0]    n_eff;
    logic [CW+2:0] pad_pos;
    logic          pad_fits;
    logic [31:0]   masked_word;

    // Byte counts above 4 saturate; pad_pos is the byte index right after the message.
    assign n_eff    = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
    assign pad_pos  = {1'b0, word_cnt, 2'b00} + {{CW{1'b0}}, n_eff};
    assign pad_fits = (int'(pad_pos) < RATE_BYTES);

    assign in_ready = (state == FILL);
    assign busy     = (state != FILL) || (word_cnt != '0);
    assign blk_data = blk_buf;

    // Keep only the valid low bytes of the final message word.
    always_comb begin
        masked_word = '0;
        for (int k = 0; k < 4; k++) begin
            if (k < int'(n_eff)) begin
                masked_word[8*k +: 8] = in_data[8*k +: 8];
            end
        end
    end

    // Buffer contents after capturing the current word, including padding on the last word.
    always_comb begin
        fill_next = blk_buf;
        for (int i = 0; i < RATE_WORDS; i++) begin
            if (i == int'(word_cnt)) begin
                fill_next[32*i +: 32] = in_last ? masked_word : in_data;
            end else if (in_last && (i > int'(word_cnt))) begin
                fill_next[32*i +: 32] = '0;
            end
        end
        if (in_last && pad_fits) begin
            for (int b = 0; b < RATE_BYTES; b++) begin
                if (b == int'(pad_pos)) begin
                    fill_next[8*b +: 8] = fill_next[8*b +: 8] | DOMAIN_BYTE;
                end
            end
            fill_next[BW-1 -: 8] = fill_next[BW-1 -: 8] | 8'h80;
        end
    end

    // Pad-only block used when the message ended exactly on a rate boundary.
    always_comb begin
        pad_block            = '0;
        pad_block[7:0]       = DOMAIN_BYTE;
        pad_block[BW-1 -: 8] = pad_block[BW-1 -: 8] | 8'h80;
    end

    // Fill / emit sequencing; clr wins over any handshake in the same cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state     <= FILL;
            word_cnt  <= '0;
            pend_pad  <= 1'b0;
            blk_buf   <= '0;
            blk_valid <= 1'b0;
            blk_last  <= 1'b0;
        end else if (clr) begin
            state     <= FILL;
            word_cnt  <= '0;
            pend_pad  <= 1'b0;
            blk_buf   <= '0;
            blk_valid <= 1'b0;
            blk_last  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        blk_buf <= fill_next;
                        if (in_last) begin
                            word_cnt  <= '0;
                            blk_valid <= 1'b1;
                            if (pad_fits) begin
                                state    <= FINAL;
                                blk_last <= 1'b1;
                            end else begin
                                state    <= EMIT;
                                pend_pad <= 1'b1;
                                blk_last <= 1'b0;
                            end
                        end else if (int'(word_cnt) == RATE_WORDS - 1) begin
                            state     <= EMIT;
                            word_cnt  <= '0;
                            blk_valid <= 1'b1;
                            blk_last  <= 1'b0;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (blk_ready) begin
                        if (pend_pad) begin
                            blk_buf  <= pad_block;
                            pend_pad <= 1'b0;
                            state    <= FINAL;
                            blk_last <= 1'b1;
                        end else begin
                            blk_buf   <= '0;
                            state     <= FILL;
                            blk_valid <= 1'b0;
                        end
                    end
                end
                FINAL: begin
                    if (blk_ready) begin
                        blk_buf   <= '0;
                        word_cnt  <= '0;
                        state     <= FILL;
                        blk_valid <= 1'b0;
                        blk_last  <= 1'b0;
                    end
                end
                default: begin
                    state     <= FILL;
                    blk_valid <= 1'b0;
                    blk_last  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sha3_absorb_pad.sv
// tb/tb_sha3_absorb_pad.sv - self-checking bench for sha3_absorb_pad
module tb_sha3_absorb_pad;
    localparam int RW = 34;
    localparam int RB = 4 * RW;
    localparam int BW = 32 * RW;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          in_last;
    logic [2:0]    in_bytes;
    logic          blk_valid;
    logic          blk_ready;
    logic [BW-1:0] blk_data;
    logic          blk_last;
    logic          busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [BW-1:0] data;
        logic          last;
    } blk_t;

    typedef struct {
        int          len;
        logic [7:0]  base;
        bit          over;
        int          nblk;
        logic [31:0] fst_w33;
        logic [31:0] fin_w0;
        logic [31:0] fin_w1;
        logic [31:0] fin_w33;
    } vec_t;

    logic [7:0]    msg   [$];
    blk_t          got   [$];
    blk_t          exp_q [$];
    logic [BW-1:0] abc_exp;

    sha3_absorb_pad #(.RATE_WORDS(RW), .DOMAIN_BYTE(8'h06)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_last  (blk_last),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic build_msg(input int len, input logic [7:0] base);
        msg.delete();
        for (int i = 0; i < len; i++) msg.push_back(8'(int'(base) + i));
    endtask

    // Reference: pad the whole byte string, then cut it into rate blocks.
    task automatic model_blocks();
        int len;
        int nblk;
        logic [7:0] pb [$];
        len  = msg.size();
        nblk = len / RB + 1;
        exp_q.delete();
        for (int i = 0; i < nblk * RB; i++) pb.push_back(i < len ? msg[i] : 8'h00);
        pb[len]         = pb[len] | 8'h06;
        pb[nblk*RB - 1] = pb[nblk*RB - 1] | 8'h80;
        for (int b = 0; b < nblk; b++) begin
            blk_t e;
            for (int i = 0; i < RB; i++) e.data[8*i +: 8] = pb[b*RB + i];
            e.last = (b == nblk - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic check_model(input string tag);
        int n;
        model_blocks();
        chk32({tag, "_nblk"}, 32'(got.size()), 32'(exp_q.size()));
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int b = 0; b < n; b++) begin
            chkw({tag, "_data"}, got[b].data, exp_q[b].data);
            chk1({tag, "_last"}, got[b].last, exp_q[b].last);
        end
    endtask

    // Drives the message in msg and collects blocks until the final one is taken.
    task automatic send_msg(input bit rnd, input bit over);
        int len, nwords, nb, wi, cyc;
        bit done_in, done_out, after_last, holding, first;
        logic [BW-1:0] held_d;
        logic held_l;
        logic [31:0] w;
        len = msg.size();
        nwords = (len == 0) ? 1 : (len + 3) / 4;
        nb = len - 4 * (nwords - 1);
        wi = 0; cyc = 0; done_in = 0; done_out = 0; after_last = 0; holding = 0; first = 1;
        held_d = '0; held_l = 1'b0;
        got.delete();
        while (!done_out && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (first) chk1("start_ready", in_ready, 1'b1);
            first = 0;
            if (after_last) chk1("valid_continuous", blk_valid, 1'b1);
            if (holding && blk_valid) begin
                chkw("hold_data", blk_data, held_d);
                chk1("hold_last", blk_last, held_l);
            end
            if (blk_valid) chk1("in_ready_blocked", in_ready, 1'b0);
            in_valid = !done_in && (!rnd || ($urandom_range(0, 3) != 0));
            in_last = (wi == nwords - 1);
            for (int k = 0; k < 4; k++)
                w[8*k +: 8] = (4*wi + k < len) ? msg[4*wi + k] : 8'($urandom);
            in_data = w;
            if (wi == nwords - 1)
                in_bytes = (over && nb == 4) ? 3'($urandom_range(5, 7)) : 3'(nb);
            else
                in_bytes = 3'($urandom);
            blk_ready = !rnd || ($urandom_range(0, 2) == 0);
            holding = 0;
            if (blk_valid && blk_ready) begin
                got.push_back('{blk_data, blk_last});
                if (blk_last) done_out = 1;
            end else if (blk_valid) begin
                holding = 1;
                held_d = blk_data;
                held_l = blk_last;
            end
            if (in_valid && in_ready) begin
                if (wi == nwords - 1) begin
                    done_in = 1;
                    after_last = 1;
                end
                wi++;
            end
            if (done_out) after_last = 0;
            @(posedge clk);
        end
        chk1("msg_timeout", done_out, 1'b1);
    endtask

    task automatic check_abc(input string tag);
        chk32({tag, "_nblk"}, 32'(got.size()), 32'd1);
        if (got.size() > 0) begin
            chkw({tag, "_data"}, got[0].data, abc_exp);
            chk1({tag, "_last"}, got[0].last, 1'b1);
        end
    endtask

    task automatic feed_words(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_last = 1'b0; in_data = $urandom; in_bytes = 3'd4;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        vec_t tbl [8];
        int bl [14];
        int len;

        tbl[0] = '{0,   8'h00, 1'b0, 1, 32'h80000000, 32'h00000006, 32'h00000000, 32'h80000000};
        tbl[1] = '{3,   8'h61, 1'b0, 1, 32'h80000000, 32'h06636261, 32'h00000000, 32'h80000000};
        tbl[2] = '{135, 8'h00, 1'b0, 1, 32'h86868584, 32'h03020100, 32'h07060504, 32'h86868584};
        tbl[3] = '{136, 8'h00, 1'b0, 2, 32'h87868584, 32'h00000006, 32'h00000000, 32'h80000000};
        tbl[4] = '{134, 8'h10, 1'b0, 1, 32'h80069594, 32'h13121110, 32'h17161514, 32'h80069594};
        tbl[5] = '{4,   8'hA0, 1'b1, 1, 32'h80000000, 32'hA3A2A1A0, 32'h00000006, 32'h80000000};
        tbl[6] = '{140, 8'h00, 1'b1, 2, 32'h87868584, 32'h8B8A8988, 32'h00000006, 32'h80000000};
        tbl[7] = '{133, 8'hF0, 1'b0, 1, 32'h80000674, 32'hF3F2F1F0, 32'hF7F6F5F4, 32'h80000674};
        bl = '{0, 1, 3, 4, 131, 132, 133, 134, 135, 136, 137, 271, 272, 273};

        abc_exp = '0;
        abc_exp[31:0] = 32'h06636261;
        abc_exp[BW-1 -: 32] = 32'h80000000;

        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_data = '0; in_bytes = '0; blk_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk1("rst_blk_valid", blk_valid, 1'b0);
        chk1("rst_blk_last", blk_last, 1'b0);
        chkw("rst_blk_data", blk_data, '0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;

        for (int t = 0; t < 8; t++) begin
            build_msg(tbl[t].len, tbl[t].base);
            send_msg(1'b0, tbl[t].over);
            chk32("tbl_nblk", 32'(got.size()), 32'(tbl[t].nblk));
            if (got.size() > 0) begin
                chk32("tbl_fst_w33", got[0].data[32*33 +: 32], tbl[t].fst_w33);
                chk32("tbl_fin_w0", got[got.size()-1].data[31:0], tbl[t].fin_w0);
                chk32("tbl_fin_w1", got[got.size()-1].data[63:32], tbl[t].fin_w1);
                chk32("tbl_fin_w33", got[got.size()-1].data[32*33 +: 32], tbl[t].fin_w33);
                chk1("tbl_fst_last", got[0].last, (tbl[t].nblk == 1) ? 1'b1 : 1'b0);
            end
            check_model("tbl");
        end

        // Backpressure: block held for 10 cycles while the source keeps offering words.
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h00636261; in_last = 1'b1; in_bytes = 3'd3; blk_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk1("bp_valid_rise", blk_valid, 1'b1);
        in_data = 32'hDEADBEEF; in_bytes = 3'd4;
        for (int c = 0; c < 10; c++) begin
            chkw("bp_data", blk_data, abc_exp);
            chk1("bp_last", blk_last, 1'b1);
            chk1("bp_in_ready", in_ready, 1'b0);
            chk1("bp_busy", busy, 1'b1);
            @(posedge clk);
            @(negedge clk);
        end
        blk_ready = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        blk_ready = 1'b0;
        chk1("bp_done_valid", blk_valid, 1'b0);
        chk1("bp_done_busy", busy, 1'b0);

        // Abort mid-fill with a simultaneous input word.
        feed_words(5);
        chk1("clr_busy_before", busy, 1'b1);
        clr = 1'b1; in_valid = 1'b1; in_last = 1'b1; in_bytes = 3'd2;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
        chk1("clr_busy", busy, 1'b0);
        chk1("clr_valid", blk_valid, 1'b0);
        build_msg(3, 8'h61);
        send_msg(1'b0, 1'b0);
        check_abc("clr_abc");

        // Abort while a final block is pending, racing a block handshake.
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h00636261; in_last = 1'b1; in_bytes = 3'd3; blk_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; clr = 1'b1; blk_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0; blk_ready = 1'b0;
        chk1("clr_pend_valid", blk_valid, 1'b0);
        chk1("clr_pend_busy", busy, 1'b0);
        build_msg(3, 8'h61);
        send_msg(1'b0, 1'b0);
        check_abc("clr_pend_abc");

        // Asynchronous reset pulse mid-fill.
        feed_words(5);
        #2 rst_n = 1'b0;
        #1;
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_valid", blk_valid, 1'b0);
        chk1("mid_rst_ready", in_ready, 1'b1);
        chkw("mid_rst_data", blk_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        build_msg(3, 8'h61);
        send_msg(1'b0, 1'b0);
        check_abc("rst_abc");

        // Random messages, random flow control, back to back.
        for (int m = 0; m < 40; m++) begin
            len = ($urandom_range(0, 2) == 0) ? bl[$urandom_range(0, 13)] : int'($urandom_range(0, 300));
            msg.delete();
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            send_msg(1'b1, 1'($urandom_range(0, 1)));
            check_model("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
